mem_refill_arbiter: RTL

Sequencer and arbiter in front of the 13-bit-block-address, 128-bit-block main memory. Two cache controllers (port 0: instruction cache, port 1: data cache) request whole-block refills. The block serialises them onto the single memory address bus, models a fixed memory access latency, and returns the captured 128-bit block with a one-cycle ready pulse to the winning requester.

---
 rtl/mem_refill_arbiter_pkg.sv | 20 ++
 rtl/mem_refill_arbiter_grant.sv | 35 +++
 rtl/mem_refill_arbiter.sv | 99 +++++++++
 3 files changed

// File: rtl/mem_refill_arbiter_pkg.sv
// Shared definitions for the main-memory refill arbiter: bus widths,
// sequencer state encoding and the requester-owner type.
package mem_pkg;

    localparam int BLOCK_ADDR_W = 13;
    localparam int BLOCK_DATA_W = 128;

    // Counter wide enough for the largest supported access latency (15)
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // 0 = instruction cache port, 1 = data cache port
    typedef logic owner_t;

endpackage

// File: rtl/mem_refill_arbiter_grant.sv
// Combinational grant decision between the two refill ports.
// Build option: define ROUND_ROBIN_EN to alternate ties between ports;
// otherwise port 0 has fixed priority on ties.
module refill_grant
    import mem_pkg::*;
(
    input  logic   req0,
    input  logic   req1,
    input  owner_t lastGrant,
    output logic   grantValid,
    output owner_t grantOwner
);

`ifndef ROUND_ROBIN_EN
    // Fixed priority ignores the history; keep the input tied off quietly
    logic unused_last_grant;
    assign unused_last_grant = lastGrant;
`endif

    // Pick a winner whenever at least one port is requesting
    always_comb begin
        grantValid = req0 | req1;
        grantOwner = 1'b0;
        if (req0 && req1) begin
`ifdef ROUND_ROBIN_EN
            grantOwner = ~lastGrant;
`else
            grantOwner = 1'b0;
`endif
        end else if (req1) begin
            grantOwner = 1'b1;
        end
    end

endmodule

// File: rtl/mem_refill_arbiter.sv
// Refill sequencer: serialises block refills from the instruction and data
// caches onto one memory address bus, waits a fixed access latency, captures
// the block and pulses ready to the owner for one cycle.
// Build option: ROUND_ROBIN_EN selects round-robin tie breaking (adds the
// lastGrant history register); undefined gives fixed port-0 priority.
module mem_refill_arbiter
    import mem_pkg::*;
#(
    parameter int LATENCY = 4
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req0,
    input  logic [BLOCK_ADDR_W-1:0] addr0,
    input  logic                    req1,
    input  logic [BLOCK_ADDR_W-1:0] addr1,
    output logic [BLOCK_ADDR_W-1:0] memAddress,
    input  logic [BLOCK_DATA_W-1:0] memData,
    output logic                    ready0,
    output logic                    ready1,
    output logic [BLOCK_DATA_W-1:0] outData,
    output logic                    busy
);

    state_t           state;
    owner_t           owner;
    logic [CNT_W-1:0] cnt;
    logic             grantValid;
    owner_t           grantOwner;
    owner_t           last_grant_w;

`ifdef ROUND_ROBIN_EN
    owner_t lastGrant;
    assign last_grant_w = lastGrant;
`else
    assign last_grant_w = 1'b1;
`endif

    refill_grant u_grant (
        .req0       (req0),
        .req1       (req1),
        .lastGrant  (last_grant_w),
        .grantValid (grantValid),
        .grantOwner (grantOwner)
    );

    // Sequencer: grant in IDLE, count out the memory latency, then pulse ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            cnt        <= '0;
            memAddress <= '0;
            outData    <= '0;
            ready0     <= 1'b0;
            ready1     <= 1'b0;
            busy       <= 1'b0;
`ifdef ROUND_ROBIN_EN
            lastGrant  <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grantValid) begin
                        memAddress <= grantOwner ? addr1 : addr0;
                        owner      <= grantOwner;
                        cnt        <= CNT_W'(LATENCY - 1);
                        busy       <= 1'b1;
                        state      <= WAIT;
`ifdef ROUND_ROBIN_EN
                        lastGrant  <= grantOwner;
`endif
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        outData <= memData;
                        ready0  <= (owner == 1'b0);
                        ready1  <= (owner == 1'b1);
                        state   <= DONE;
                    end
                end
                DONE: begin
                    ready0 <= 1'b0;
                    ready1 <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
